adc_serial_reg_writer: RTL and testbench
========================================

# adc_serial_reg_writer

Serial register writer between `ADC_FSM` and the ADC's 3-wire control port (SCLK/SDATA/SCS).
- Accepts level requests from the power/calibration FSM: init, DES enable, DES disable.
- Shifts fixed 32-bit register frames MSB-first.
- Pulses `Done` once the whole sequence has been sent.
- Drives the `Sclk`, `Sdata` and `Select` signals that the FSM tri-states onto the pins.

## Interface
- `CLK_DIV`, 4: clocks per SCLK half-period (≥1); one bit = 2*CLK_DIV clocks.
- `GAP_CYCLES`, 8: clocks Select is held high after every frame (≥1).
- `CFG_DATA`, 16'h92FF: configuration register data, DES bit clear.
- `DES_BIT`, 13: bit index of DES enable in `CFG_DATA`.
- `OFFSET_DATA`, 16'h007F: offset register data, written at init.
- `FS_DATA`, 16'h807F: full-scale register data, written at init.
- `EXT_DATA`, 16'hFFFF: extended config register data, written at init.
- `Clock`, in, 1: system clock.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Init`, in, 1: request the 4-frame init sequence (level).
- `DesEnable`, in, 1: request a config write with the DES bit set (level).
- `DesDisable`, in, 1: request a config write with the DES bit cleared (level).
- `Sclk`, out, 1: serial clock; idles low.
- `Sdata`, out, 1: serial data; changes only while Sclk is low.
- `Select`, out, 1: active-low chip select.
- `Done`, out, 1: one-cycle pulse when the sequence completes.
- `Busy`, out, 1: high from acceptance until the Done cycle, inclusive.

## Operation
- Frame format is {12'h001, addr[3:0], data[15:0]}, sent MSB first.
- Sequences:
  - Init sends four frames in order: {1, CFG_DATA & ~(1<<DES_BIT)}, {2, OFFSET_DATA}, {3, FS_DATA}, {D, EXT_DATA}.
  - DesEnable sends one frame: {1, CFG_DATA | (1<<DES_BIT)}.
  - DesDisable sends one frame: {1, CFG_DATA & ~(1<<DES_BIT)}.
- Request priority when several are high in IDLE: Init > DesDisable > DesEnable.
- Requests are sampled only in IDLE and ignored otherwise; no queuing.
- States:
  - IDLE → SHIFT when any request is high. Latch the sequence select, frame index = 0, bit counter = 31.
  - SHIFT: 32 bit periods. Each bit is CLK_DIV clocks with Sclk=0, then CLK_DIV clocks with Sclk=1. Sdata is updated at the start of each low phase.
  - SHIFT → GAP after the high phase of bit 0 (Sclk=0, Select=1).
  - GAP: GAP_CYCLES clocks. Then go to SHIFT with the next frame if frames remain, otherwise go to DONE.
  - DONE: Done=1 for one cycle, then IDLE.
- Counters:
  - Divider counter runs 0..CLK_DIV-1.
  - Bit counter is 5 bits and counts down.
  - Frame index is 2 bits.
  - Gap counter is sized for GAP_CYCLES.
  - None of them wrap inside a state; all reload on state entry.
- A request still high in the IDLE cycle after Done restarts the sequence. The requester must drop the request on Done; `ADC_FSM` leaves its state on Done, which satisfies this.

## Timing
- Reset values: Sclk=0, Sdata=0, Select=1, Done=0, Busy=0, state IDLE. Reset applies immediately, asynchronously, including mid-frame. Release is synchronous to `Clock`.
- Request high at edge 0 (IDLE) gives Select=0, Busy=1 and Sdata=frame[31] from edge 1.
- Select stays low for exactly 64*CLK_DIV clocks per frame, which is 256 at the default.
- Rising Sclk edges per frame = 32. Sdata is stable for CLK_DIV clocks before and after every rising edge.
- After each frame, Select is high for exactly GAP_CYCLES clocks before the next frame's Select falls.
- Done is high in cycle 1 + F*(64*CLK_DIV + GAP_CYCLES), where F = frames:
  - single-frame sequences at defaults: 265;
  - Init at defaults: 1057.
- Busy falls on the cycle after Done.
- Sdata returns to 0 whenever Select=1.

## Test plan
- Reset: assert Reset_n=0 mid-frame (Select low) → Sclk=0, Select=1, Sdata=0, Busy=0 within the same cycle. After release, no activity until a request.
- DesEnable held until Done, bench sampling Sdata on Sclk rise:
  - captured frame = 32'h0011B2FF;
  - 32 rising edges while Select is low;
  - Done at cycle 265;
  - single pulse.
- DesDisable → captured frame = 32'h001192FF; Done at cycle 265.
- Init:
  - frames, in order: 32'h001192FF, 32'h0012007F, 32'h0013807F, 32'h001DFFFF;
  - Select high for 8 clocks between frames;
  - Done at cycle 1057.
- Simultaneous requests:
  - Init+DesEnable at the same edge → Init sequence only.
  - DesEnable+DesDisable → 32'h001192FF.
  - DesEnable pulsed during Busy → ignored, no extra frame.
- Request held high 3 cycles past Done → second complete sequence starts in the IDLE cycle after Done. Bench confirms Select falls again after exactly 1 IDLE cycle.

Source files
------------

// File: rtl/adc_serial_reg_writer_if.sv
// Request/status and 3-wire serial bundle between ADC_FSM
// and the ADC serial register writer.
interface adc_serial_reg_writer_if;
   logic Init;
   logic DesEnable;
   logic DesDisable;
   logic Sclk;
   logic Sdata;
   logic Select;
   logic Done;
   logic Busy;

   modport master (
      output Init, DesEnable, DesDisable,
      input  Sclk, Sdata, Select, Done, Busy
   );

   modport slave (
      input  Init, DesEnable, DesDisable,
      output Sclk, Sdata, Select, Done, Busy
   );
endinterface

// File: rtl/adc_serial_reg_writer.sv
// Shifts fixed 32-bit register frames MSB-first onto the ADC
// 3-wire control port for init and DES on/off requests.
module adc_serial_reg_writer #(
   parameter int          CLK_DIV     = 4,
   parameter int          GAP_CYCLES  = 8,
   parameter logic [15:0] CFG_DATA    = 16'h92FF,
   parameter int          DES_BIT     = 13,
   parameter logic [15:0] OFFSET_DATA = 16'h007F,
   parameter logic [15:0] FS_DATA     = 16'h807F,
   parameter logic [15:0] EXT_DATA    = 16'hFFFF
) (
   input logic                     Clock,
   input logic                     Reset_n,
   adc_serial_reg_writer_if.slave  bus
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [15:0] DES_MASK = 16'(1) << DES_BIT;
   localparam logic [15:0] CFG_ON   = CFG_DATA | DES_MASK;
   localparam logic [15:0] CFG_OFF  = CFG_DATA & ~DES_MASK;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
   typedef enum logic [1:0] {SEQ_INIT, SEQ_DES_OFF, SEQ_DES_ON} seq_t;

   state_t        state, stateNext;
   seq_t          seq, seqNext;
   logic [1:0]    frameIdx, frameIdxNext;
   logic [4:0]    bitCnt, bitCntNext;
   logic [DW-1:0] divCnt, divCntNext;
   logic [GW-1:0] gapCnt, gapCntNext;
   logic          phaseHigh, phaseHighNext;

   logic [3:0]    frameAddr;
   logic [15:0]   frameData;
   logic [31:0]   frame;
   logic [1:0]    lastIdx;
   logic          anyReq;

   always_comb begin
      frameAddr = 4'h1;
      frameData = CFG_OFF;
      if (seq == SEQ_DES_ON) begin
         frameData = CFG_ON;
      end else if (seq == SEQ_INIT) begin
         unique case (frameIdx)
            2'd0: frameData = CFG_OFF;
            2'd1: begin frameAddr = 4'h2; frameData = OFFSET_DATA; end
            2'd2: begin frameAddr = 4'h3; frameData = FS_DATA; end
            2'd3: begin frameAddr = 4'hD; frameData = EXT_DATA; end
         endcase
      end
      frame = {12'h001, frameAddr, frameData};
   end

   assign lastIdx = (seq == SEQ_INIT) ? 2'd3 : 2'd0;
   assign anyReq  = bus.Init | bus.DesDisable | bus.DesEnable;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         seq       <= SEQ_INIT;
         frameIdx  <= '0;
         bitCnt    <= '0;
         divCnt    <= '0;
         gapCnt    <= '0;
         phaseHigh <= 1'b0;
      end else begin
         state     <= stateNext;
         seq       <= seqNext;
         frameIdx  <= frameIdxNext;
         bitCnt    <= bitCntNext;
         divCnt    <= divCntNext;
         gapCnt    <= gapCntNext;
         phaseHigh <= phaseHighNext;
      end
   end

   always_comb begin
      stateNext     = state;
      seqNext       = seq;
      frameIdxNext  = frameIdx;
      bitCntNext    = bitCnt;
      divCntNext    = divCnt;
      gapCntNext    = gapCnt;
      phaseHighNext = phaseHigh;
      unique case (state)
         IDLE: begin
            if (anyReq) begin
               stateNext     = SHIFT;
               frameIdxNext  = 2'd0;
               bitCntNext    = 5'd31;
               divCntNext    = '0;
               phaseHighNext = 1'b0;
               if (bus.Init)            seqNext = SEQ_INIT;
               else if (bus.DesDisable) seqNext = SEQ_DES_OFF;
               else                     seqNext = SEQ_DES_ON;
            end
         end
         SHIFT: begin
            if (divCnt == DIV_LAST) begin
               divCntNext = '0;
               if (!phaseHigh) begin
                  phaseHighNext = 1'b1;
               end else if (bitCnt == 5'd0) begin
                  stateNext  = GAP;
                  gapCntNext = '0;
               end else begin
                  phaseHighNext = 1'b0;
                  bitCntNext    = bitCnt - 5'd1;
               end
            end else begin
               divCntNext = divCnt + DW'(1);
            end
         end
         GAP: begin
            if (gapCnt == GAP_LAST) begin
               if (frameIdx == lastIdx) begin
                  stateNext = DONE;
               end else begin
                  stateNext     = SHIFT;
                  frameIdxNext  = frameIdx + 2'd1;
                  bitCntNext    = 5'd31;
                  divCntNext    = '0;
                  phaseHighNext = 1'b0;
               end
            end else begin
               gapCntNext = gapCnt + GW'(1);
            end
         end
         DONE: stateNext = IDLE;
      endcase
   end

   // Outputs decode straight from state so async reset hits the pins at once.
   assign bus.Select = (state != SHIFT);
   assign bus.Sclk   = (state == SHIFT) && phaseHigh;
   assign bus.Sdata  = (state == SHIFT) && frame[bitCnt];
   assign bus.Done   = (state == DONE);
   assign bus.Busy   = (state != IDLE);

endmodule

// File: tb/tb_adc_serial_reg_writer.sv
// Directed bench for adc_serial_reg_writer with a frame
// scoreboard fed by an Sclk-rise capture monitor.
module tb_adc_serial_reg_writer;

   localparam int CLK_DIV = 4;
   localparam int GAP     = 8;
   localparam int FRAME_CYC = 64 * CLK_DIV;

   logic Clock = 1'b0;
   logic Reset_n;
   int   total = 0;
   int   bad   = 0;

   logic [31:0] expQ[$];
   logic [31:0] capQ[$];
   int          bitQ[$];
   logic [31:0] shiftIn = '0;
   int          nBits = 0;

   adc_serial_reg_writer_if bus();

   adc_serial_reg_writer dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clock = ~Clock;

   always @(negedge bus.Select) begin
      shiftIn = '0;
      nBits   = 0;
   end

   always @(posedge bus.Sclk) begin
      if (bus.Select === 1'b0) begin
         shiftIn = {shiftIn[30:0], bus.Sdata};
         nBits++;
      end
   end

   always @(posedge bus.Select) begin
      capQ.push_back(shiftIn);
      bitQ.push_back(nBits);
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic dropReqs();
      bus.Init       = 1'b0;
      bus.DesEnable  = 1'b0;
      bus.DesDisable = 1'b0;
   endtask

   // Call right after the posedge that samples the request (edge 0).
   task automatic watch(input string tag, input int frames,
                        input int expDone, input int dropAt,
                        input int glitchAt);
      int k = 0;
      int lowCyc = 0;
      int falls = 0;
      int gapRun = 0;
      int badGap = 0;
      int idleViol = 0;
      logic prevSel = 1'b1;
      bit seen = 1'b0;
      logic [31:0] f0;
      logic [31:0] got;
      logic [31:0] want;
      int nb;
      f0 = expQ[0];
      while (!seen && k < 3000) begin
         @(negedge Clock);
         k++;
         if (k == 1) begin
            check({tag, " sel_c1"}, bus.Select, 0);
            check({tag, " busy_c1"}, bus.Busy, 1);
            check({tag, " sdata_c1"}, bus.Sdata, f0[31]);
         end
         if (k == glitchAt) bus.DesEnable = 1'b1;
         if (k == glitchAt + 3) bus.DesEnable = 1'b0;
         if (k == dropAt) dropReqs();
         if (bus.Select === 1'b0) begin
            lowCyc++;
            if (prevSel) begin
               falls++;
               if (k > 1 && gapRun != GAP) badGap++;
            end
            gapRun = 0;
         end else begin
            gapRun++;
            if (bus.Sdata !== 1'b0 || bus.Sclk !== 1'b0) idleViol++;
         end
         prevSel = bus.Select;
         if (bus.Done === 1'b1) seen = 1'b1;
      end
      check({tag, " done_cycle"}, k, expDone);
      check({tag, " busy_at_done"}, bus.Busy, 1);
      check({tag, " sel_low_cycles"}, lowCyc, frames * FRAME_CYC);
      check({tag, " frame_count"}, falls, frames);
      check({tag, " gap_len"}, badGap, 0);
      check({tag, " last_gap"}, gapRun, GAP + 1);
      check({tag, " idle_pins"}, idleViol, 0);
      check({tag, " captured"}, capQ.size(), frames);
      for (int i = 0; i < frames; i++) begin
         want = expQ.pop_front();
         got  = (capQ.size() > 0) ? capQ.pop_front() : 'x;
         nb   = (bitQ.size() > 0) ? bitQ.pop_front() : -1;
         check($sformatf("%s frame%0d", tag, i), got, want);
         check($sformatf("%s rises%0d", tag, i), nb, 32);
      end
   endtask

   task automatic afterDone(input string tag);
      @(negedge Clock);
      check({tag, " done_single"}, bus.Done, 0);
      check({tag, " busy_fall"}, bus.Busy, 0);
   endtask

   task automatic quiet(input string tag, input int cycles);
      int act = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge Clock);
         if (bus.Select !== 1'b1 || bus.Busy !== 1'b0) act++;
      end
      check({tag, " no_activity"}, act, 0);
      check({tag, " no_frames"}, capQ.size(), 0);
   endtask

   task automatic pushInit();
      expQ.push_back(32'h001192FF);
      expQ.push_back(32'h0012007F);
      expQ.push_back(32'h0013807F);
      expQ.push_back(32'h001DFFFF);
   endtask

   initial begin
      dropReqs();
      Reset_n = 1'b0;
      #1;
      check("rst sel", bus.Select, 1);
      check("rst sclk", bus.Sclk, 0);
      check("rst sdata", bus.Sdata, 0);
      check("rst done", bus.Done, 0);
      check("rst busy", bus.Busy, 0);
      repeat (3) @(negedge Clock);
      Reset_n = 1'b1;
      repeat (3) @(negedge Clock);
      capQ.delete();
      bitQ.delete();

      expQ.push_back(32'h0011B2FF);
      bus.DesEnable = 1'b1;
      @(posedge Clock);
      watch("desen", 1, 265, 265, -10);
      afterDone("desen");

      expQ.push_back(32'h001192FF);
      bus.DesDisable = 1'b1;
      @(posedge Clock);
      watch("desdis", 1, 265, 265, 100);
      afterDone("desdis");
      quiet("busy_glitch", 20);

      pushInit();
      bus.Init = 1'b1;
      @(posedge Clock);
      watch("init", 4, 1057, 1057, -10);
      afterDone("init");

      pushInit();
      bus.Init      = 1'b1;
      bus.DesEnable = 1'b1;
      @(posedge Clock);
      watch("init_en", 4, 1057, 1057, -10);
      afterDone("init_en");

      expQ.push_back(32'h001192FF);
      bus.DesEnable  = 1'b1;
      bus.DesDisable = 1'b1;
      @(posedge Clock);
      watch("en_dis", 1, 265, 265, -10);
      afterDone("en_dis");
      quiet("post_en_dis", 20);

      expQ.push_back(32'h0011B2FF);
      expQ.push_back(32'h0011B2FF);
      bus.DesEnable = 1'b1;
      @(posedge Clock);
      watch("hold1", 1, 265, -1, -10);
      @(negedge Clock);
      check("hold idle sel", bus.Select, 1);
      check("hold idle busy", bus.Busy, 0);
      @(posedge Clock);
      watch("hold2", 1, 265, 2, -10);
      afterDone("hold2");
      quiet("post_hold", 20);

      bus.DesEnable = 1'b1;
      @(posedge Clock);
      repeat (100) @(negedge Clock);
      check("mid sel_low", bus.Select, 0);
      #2;
      Reset_n = 1'b0;
      dropReqs();
      #1;
      check("mid rst sclk", bus.Sclk, 0);
      check("mid rst sel", bus.Select, 1);
      check("mid rst sdata", bus.Sdata, 0);
      check("mid rst busy", bus.Busy, 0);
      @(negedge Clock);
      Reset_n = 1'b1;
      capQ.delete();
      bitQ.delete();
      quiet("post_rst", 30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
